// File: rtl/dmux8way_pkg.sv
// dmux8way_pkg: shared lane constants, FSM state type and the round-robin search helper.
package dmux8way_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {EMPTY, FULL, STALLED} state_t;

    // Returns {found, idx}: first set mask bit after ptr, wrapping 7->0, ptr itself checked last.
    function automatic logic [SEL_W:0] rr_next(input logic [SEL_W-1:0] ptr, input logic [N_LANES-1:0] mask);
        logic [SEL_W:0]   r;
        logic [SEL_W-1:0] k;
        r = '0;
        for (int i = N_LANES; i >= 1; i--) begin
            k = ptr + SEL_W'(i);
            if (mask[k]) r = {1'b1, k};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmux8way_rr_pick.sv
// dmux8way_rr_pick: combinational round-robin lane picker shared by grant and retarget paths.
module dmux8way_rr_pick
    import dmux8way_pkg::*;
(
    input  logic [SEL_W-1:0]   ptr,
    input  logic [N_LANES-1:0] mask,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    assign {found, idx} = rr_next(ptr, mask);

endmodule

// File: rtl/dmux8way_dispatcher.sv
// dmux8way_dispatcher: round-robin 8-way dispatcher with a one-entry hold register and stall detection.
// Optional DMUX8_RETARGET_EN moves a stalled item to the next enabled lane.
module dmux8way_dispatcher
    import dmux8way_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int STALL_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [N_LANES-1:0]        lane_en,
    output logic [N_LANES-1:0]        out_valid,
    input  logic [N_LANES-1:0]        out_ready,
    output logic [N_LANES*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]          sel,
    output logic                      stall_err,
    input  logic                      clr_err
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);

    state_t             state, state_nx;
    logic [DATA_W-1:0]  data_q;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   stall_cnt;
    logic               drain, accept, hit;
    logic               grant_found, rt_found;
    logic [SEL_W-1:0]   grant_idx, rt_idx;

    dmux8way_rr_pick u_grant (
        .ptr   (ptr),
        .mask  (lane_en),
        .found (grant_found),
        .idx   (grant_idx)
    );

`ifdef DMUX8_RETARGET_EN
    dmux8way_rr_pick u_retarget (
        .ptr   (sel),
        .mask  (lane_en & ~(8'b1 << sel)),
        .found (rt_found),
        .idx   (rt_idx)
    );
`else
    assign rt_found = 1'b0;
    assign rt_idx   = sel;
`endif

    // Accept implies drain while holding, so !drain here also means no accept.
    assign hit = (state == FULL) && !drain && (stall_cnt == CNT_W'(STALL_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == EMPTY || drain) state_nx = accept ? FULL : EMPTY;
        else if (hit)                state_nx = rt_found ? FULL : STALLED;
    end

    always_comb begin
        out_valid = (state != EMPTY) ? (8'b1 << sel) : '0;
        drain     = |(out_valid & out_ready);
        in_ready  = rst_n && grant_found && (state == EMPTY || drain);
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            sel       <= 3'd7;
            ptr       <= 3'd7;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= in_data;
                sel    <= grant_idx;
                ptr    <= grant_idx;
            end else if (hit && rt_found) begin
                sel    <= rt_idx;
            end
            if (accept || drain || (hit && rt_found))
                stall_cnt <= '0;
            else if (state != EMPTY && stall_cnt != CNT_W'(STALL_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hit)          stall_err <= 1'b1;
            else if (clr_err) stall_err <= 1'b0;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign out_data[k*DATA_W +: DATA_W] = out_valid[k] ? data_q : '0;
    end

endmodule
